fetch_pc_stage: RTL and testbench

Instruction-fetch front end that sits directly upstream of the branch predictor. It owns the architectural fetch PC and drives it to the predictor as `program_counter`. It issues one instruction-memory request at a time and chooses the next PC from the predictor's `prediction`/`predicted_address`. Returned instructions, tagged with their PC and prediction, are buffered in a small fetch queue for decode. A redirect from execute flushes the queue and discards any stale in-flight response.

---
 rtl/fetch_pc_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_fetch_pc_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_stage.sv
// ---------------------------------------------------------------------------
// fetch_pc_stage
//
// Instruction-fetch front end placed directly ahead of the branch predictor.
// Owns the architectural fetch PC, issues one instruction-memory request at a
// time, picks the next PC from the predictor, and buffers returned
// instructions (tagged with their PC and prediction) in a small fetch queue
// for decode. A redirect from execute flushes the queue and drops any stale
// in-flight response.
//
// Parameters
//   RESET_PC          fetch PC loaded on reset
//   FQ_DEPTH          fetch-queue entries (power of two, >= 2)
//
// Ports
//   clk               single clock, all state on rising edge
//   rst_n             synchronous active-low reset
//   program_counter   current fetch PC, to predictor
//   prediction        predictor taken flag for program_counter
//   predicted_address predictor next-PC for program_counter
//   imem_req_valid    request valid (address = program_counter)
//   imem_req_ready    request accept from memory
//   imem_req_addr     request address
//   imem_resp_valid   one response strobe per accepted request
//   imem_resp_data    instruction word
//   redirect_valid    mispredict/flush pulse from execute
//   redirect_pc       corrected PC
//   fq_valid          queue head valid
//   fq_ready          decode pops head on fq_valid & fq_ready
//   fq_instr          head instruction
//   fq_pc             head PC
//   fq_pred_target    head predicted next-PC
//   fq_pred_taken     head prediction bit
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FETCH | no request outstanding; request issued when the queue has space
// S_WAIT  | one request outstanding, its response is pushed to the queue
// S_DRAIN | one stale request outstanding, its response is dropped
// ---------------------------------------------------------------------------
module fetch_pc_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] program_counter,
    input  logic        prediction,
    input  logic [31:0] predicted_address,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fq_valid,
    input  logic        fq_ready,
    output logic [31:0] fq_instr,
    output logic [31:0] fq_pc,
    output logic [31:0] fq_pred_target,
    output logic        fq_pred_taken
);

    localparam int unsigned      PTR_W   = $clog2(FQ_DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [31:0]      r_pc;
    logic [31:0]      w_pc_nxt;

    // Tag of the request currently in flight
    logic [31:0]      r_if_pc;
    logic             r_if_taken;
    logic [31:0]      r_if_target;

    // Fetch queue storage
    logic [31:0]      r_fq_instr  [FQ_DEPTH];
    logic [31:0]      r_fq_pc     [FQ_DEPTH];
    logic [31:0]      r_fq_target [FQ_DEPTH];
    logic             r_fq_taken  [FQ_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_has_space;
    logic             w_req_valid;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;

    // -----------------------------------------------------------------------
    // Handshake qualifiers
    // -----------------------------------------------------------------------
    always_comb begin
        w_has_space = (r_count < DEPTH_C);
        // The count only grows in S_WAIT, so a raised request in S_FETCH
        // stays raised until the memory takes it.
        w_req_valid = rst_n && (r_state == S_FETCH) && w_has_space;
        w_accept    = w_req_valid && imem_req_ready;
        // A redirect wins over a same-cycle response and pop: the response
        // belongs to the wrong path and the queue is being emptied anyway.
        w_push      = imem_resp_valid && (r_state == S_WAIT) && !redirect_valid;
        w_pop       = (r_count != '0) && fq_ready && !redirect_valid;
    end

    // -----------------------------------------------------------------------
    // Next state and next PC
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_FETCH: begin
                // An accepted request cannot be retracted; if it was accepted
                // alongside a redirect its response must be dropped.
                if (w_accept) begin
                    w_state_nxt = redirect_valid ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    w_state_nxt = S_FETCH;
                end else if (redirect_valid) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_resp_valid) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_comb begin
        w_pc_nxt = r_pc;
        if (redirect_valid) begin
            w_pc_nxt = redirect_pc;
        end else if (w_accept) begin
            // Wraps modulo 2^32 at the top of the address space
            w_pc_nxt = prediction ? predicted_address : (r_pc + 32'd4);
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_if_pc     <= '0;
            r_if_taken  <= 1'b0;
            r_if_target <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_accept) begin
                r_if_pc     <= r_pc;
                r_if_taken  <= prediction;
                r_if_target <= predicted_address;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Fetch queue
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
                r_fq_instr[PTR_W'(i)]  <= '0;
                r_fq_pc[PTR_W'(i)]     <= '0;
                r_fq_target[PTR_W'(i)] <= '0;
                r_fq_taken[PTR_W'(i)]  <= 1'b0;
            end
        end else if (redirect_valid) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // Space was checked when the request was issued, so a push
            // never lands on a full queue.
            if (w_push) begin
                r_fq_instr[r_tail]  <= imem_resp_data;
                r_fq_pc[r_tail]     <= r_if_pc;
                r_fq_target[r_tail] <= r_if_target;
                r_fq_taken[r_tail]  <= r_if_taken;
                r_tail              <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        program_counter = r_pc;
        imem_req_addr   = r_pc;
        imem_req_valid  = w_req_valid;
        fq_valid        = (r_count != '0);
        fq_instr        = r_fq_instr[r_head];
        fq_pc           = r_fq_pc[r_head];
        fq_pred_target  = r_fq_target[r_head];
        fq_pred_taken   = r_fq_taken[r_head];
    end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_stage
//
// Drives fetch_pc_stage with a latency-configurable instruction memory, a
// combinational predictor and a decode consumer. A transaction-level model
// (fetch PC, outstanding/stale flag, queue of entries) supplies every
// expected value.
// ---------------------------------------------------------------------------
module tb_fetch_pc_stage;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] program_counter;
    logic        prediction;
    logic [31:0] predicted_address;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fq_valid;
    logic        fq_ready = 1'b0;
    logic [31:0] fq_instr;
    logic [31:0] fq_pc;
    logic [31:0] fq_pred_target;
    logic        fq_pred_taken;

    fetch_pc_stage #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .program_counter   (program_counter),
        .prediction        (prediction),
        .predicted_address (predicted_address),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .fq_valid          (fq_valid),
        .fq_ready          (fq_ready),
        .fq_instr          (fq_instr),
        .fq_pc             (fq_pc),
        .fq_pred_target    (fq_pred_target),
        .fq_pred_taken     (fq_pred_taken)
    );

    always #5 clk = ~clk;

    // Stimulus knobs
    int          ready_pct = 100;
    int          pop_pct   = 100;
    int          mem_lat   = 1;
    bit          spurious  = 1'b0;
    bit          pred_rand = 1'b0;
    bit          pred_one  = 1'b0;
    logic [31:0] pred_one_pc  = '0;
    logic [31:0] pred_one_tgt = '0;

    // Predictor stimulus
    always_comb begin
        prediction = (pred_one && program_counter == pred_one_pc) ||
                     (pred_rand && program_counter[4:2] == 3'd5);
        predicted_address = (pred_one && program_counter == pred_one_pc) ? pred_one_tgt :
            {program_counter[31:12] ^ 20'h5A5A5, program_counter[11:2] + 10'd37, 2'b00};
    end

    function automatic logic f_taken(input logic [31:0] pc);
        return (pred_one && pc == pred_one_pc) || (pred_rand && pc[4:2] == 3'd5);
    endfunction

    function automatic logic [31:0] f_target(input logic [31:0] pc);
        if (pred_one && pc == pred_one_pc) return pred_one_tgt;
        return {pc[31:12] ^ 20'h5A5A5, pc[11:2] + 10'd37, 2'b00};
    endfunction

    // Reference model
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    ent_t        m_q[$];
    ent_t        m_if;
    logic [31:0] m_pc = RPC;
    bit          m_out = 1'b0;
    bit          m_stale = 1'b0;
    int          mem_wait = 0;

    bit          ev_accept;
    logic [31:0] ev_addr;
    logic [31:0] ev_exp;

    int n_checks = 0;
    int n_pass   = 0;

    // One clock: drive inputs in the low phase, advance the model for the
    // coming edge, then return at the following falling edge.
    task automatic tick(input bit redir, input logic [31:0] rpc);
        bit   exp_valid, acc, rsp, pop;
        ent_t e;
        redirect_valid  = redir;
        redirect_pc     = rpc;
        imem_req_ready  = ($urandom_range(99) < ready_pct);
        fq_ready        = ($urandom_range(99) < pop_pct);
        imem_resp_data  = $urandom;
        imem_resp_valid = (m_out && mem_wait == 0) ||
                          (!m_out && spurious && $urandom_range(3) == 0);
        #1;
        exp_valid = !m_out && (m_q.size() < DEPTH);
        acc       = exp_valid && imem_req_ready;
        rsp       = m_out && imem_resp_valid;
        pop       = (m_q.size() != 0) && fq_ready && !redir;
        ev_accept = acc;
        ev_addr   = imem_req_addr;
        ev_exp    = m_pc;
        if (m_out && !rsp) mem_wait--;
        if (redir) begin
            m_q.delete();
            m_pc = rpc;
            if (rsp) m_out = 1'b0;
            else if (m_out) m_stale = 1'b1;
            if (acc) begin
                m_out = 1'b1; m_stale = 1'b1; mem_wait = mem_lat - 1;
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (rsp) begin
                if (!m_stale) begin
                    e = m_if;
                    e.instr = imem_resp_data;
                    m_q.push_back(e);
                end
                m_out = 1'b0;
            end
            if (acc) begin
                m_if.instr  = '0;
                m_if.pc     = m_pc;
                m_if.taken  = f_taken(m_pc);
                m_if.target = f_target(m_pc);
                m_pc        = m_if.taken ? m_if.target : m_pc + 32'd4;
                m_out = 1'b1; m_stale = 1'b0; mem_wait = mem_lat - 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b1;
        fq_ready        = 1'b1;
        imem_resp_valid = 1'b1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); else n_pass++;
        n_checks++; if (fq_valid !== 1'b0) $display("FAIL reset_fq_valid got=%b exp=0", fq_valid); else n_pass++;
        n_checks++; if (fq_instr !== 32'h0) $display("FAIL reset_fq_instr got=%h exp=0", fq_instr); else n_pass++;
        n_checks++; if (fq_pc !== 32'h0) $display("FAIL reset_fq_pc got=%h exp=0", fq_pc); else n_pass++;
        n_checks++; if (fq_pred_target !== 32'h0) $display("FAIL reset_fq_target got=%h exp=0", fq_pred_target); else n_pass++;
        n_checks++; if (fq_pred_taken !== 1'b0) $display("FAIL reset_fq_taken got=%b exp=0", fq_pred_taken); else n_pass++;
        n_checks++; if (program_counter !== RPC) $display("FAIL reset_pc got=%h exp=%h", program_counter, RPC); else n_pass++;
        n_checks++; if (imem_req_addr !== RPC) $display("FAIL reset_addr got=%h exp=%h", imem_req_addr, RPC); else n_pass++;
        m_q.delete(); m_pc = RPC; m_out = 1'b0; m_stale = 1'b0; mem_wait = 0;
        imem_resp_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req_valid !== 1'b1) $display("FAIL release_req_valid got=%b exp=1", imem_req_valid); else n_pass++;
    endtask

    task automatic test_sequential();
        ready_pct = 100; pop_pct = 100; mem_lat = 1; pred_one = 0; pred_rand = 0; spurious = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, '0);
            if (i % 2 == 0) begin
                n_checks++;
                if (!ev_accept || ev_addr !== RPC + 32'(4 * (i / 2)))
                    $display("FAIL seq_req[%0d] accept=%b addr=%h exp=%h", i, ev_accept, ev_addr, RPC + 32'(4 * (i / 2)));
                else n_pass++;
            end else begin
                n_checks++;
                if (fq_valid !== 1'b1 || fq_pc !== RPC + 32'(4 * (i / 2)) || fq_pred_taken !== 1'b0)
                    $display("FAIL seq_entry[%0d] valid=%b pc=%h taken=%b exp_pc=%h", i, fq_valid, fq_pc, fq_pred_taken, RPC + 32'(4 * (i / 2)));
                else n_pass++;
            end
        end
    endtask

    task automatic test_predict();
        ready_pct = 0; pop_pct = 100;
        tick(1'b1, 32'h0000_0108);
        pred_one = 1'b1; pred_one_pc = 32'h0000_0108; pred_one_tgt = 32'h0000_0400;
        ready_pct = 100; pop_pct = 0;
        tick(1'b0, '0);
        n_checks++; if (!ev_accept || ev_addr !== 32'h108) $display("FAIL pred_req accept=%b addr=%h exp=108", ev_accept, ev_addr); else n_pass++;
        n_checks++; if (program_counter !== 32'h400) $display("FAIL pred_next_pc got=%h exp=400", program_counter); else n_pass++;
        tick(1'b0, '0);
        n_checks++;
        if (fq_valid !== 1'b1 || fq_pc !== 32'h108 || fq_pred_taken !== 1'b1 || fq_pred_target !== 32'h400)
            $display("FAIL pred_entry valid=%b pc=%h taken=%b target=%h exp 1/108/1/400", fq_valid, fq_pc, fq_pred_taken, fq_pred_target);
        else n_pass++;
        tick(1'b0, '0);
        n_checks++; if (!ev_accept || ev_addr !== 32'h400) $display("FAIL pred_target_req accept=%b addr=%h exp=400", ev_accept, ev_addr); else n_pass++;
        pred_one = 1'b0;
    endtask

    task automatic test_full();
        int accepts;
        ready_pct = 0; pop_pct = 0; mem_lat = 1;
        tick(1'b1, 32'h0000_1000);
        ready_pct = 100;
        accepts = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, '0);
            if (ev_accept) accepts++;
        end
        n_checks++; if (accepts != DEPTH) $display("FAIL full_accepts got=%0d exp=%0d", accepts, DEPTH); else n_pass++;
        n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL full_req_low got=%b exp=0", imem_req_valid); else n_pass++;
        pop_pct = 100;
        tick(1'b0, '0);
        pop_pct = 0;
        accepts = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, '0);
            if (ev_accept) accepts++;
        end
        n_checks++; if (accepts != 1) $display("FAIL full_one_more got=%0d exp=1", accepts); else n_pass++;
        n_checks++;
        if (m_q.size() == 0 || fq_valid !== 1'b1 || fq_pc !== m_q[0].pc || fq_instr !== m_q[0].instr)
            $display("FAIL full_head valid=%b pc=%h instr=%h", fq_valid, fq_pc, fq_instr);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        ready_pct = 0; pop_pct = 100; mem_lat = 1;
        tick(1'b1, 32'h0000_2000);
        for (int i = 0; i < 10 && m_out; i++) tick(1'b0, '0);
        ready_pct = 100; mem_lat = 4;
        tick(1'b0, '0);
        n_checks++; if (!ev_accept) $display("FAIL rw_accept got=0 exp=1"); else n_pass++;
        tick(1'b1, 32'h0000_0800);
        n_checks++; if (program_counter !== 32'h800 || imem_req_valid !== 1'b0)
            $display("FAIL rw_after_redirect pc=%h valid=%b exp 800/0", program_counter, imem_req_valid);
        else n_pass++;
        for (int i = 0; i < 10 && m_out; i++) begin
            tick(1'b0, '0);
            n_checks++; if (fq_valid !== 1'b0) $display("FAIL rw_no_push got=%b exp=0", fq_valid); else n_pass++;
        end
        n_checks++; if (m_out) $display("FAIL rw_timeout stale response never arrived"); else n_pass++;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h800)
            $display("FAIL rw_next_req valid=%b addr=%h exp 1/800", imem_req_valid, imem_req_addr);
        else n_pass++;
        mem_lat = 1;
        tick(1'b0, '0);
        n_checks++; if (!ev_accept || ev_addr !== 32'h800) $display("FAIL rw_req accept=%b addr=%h exp=800", ev_accept, ev_addr); else n_pass++;
    endtask

    task automatic test_redirect_accept();
        ready_pct = 0; pop_pct = 0; mem_lat = 1;
        tick(1'b1, 32'h0000_0200);
        ready_pct = 100;
        for (int i = 0; i < 20 && !(m_q.size() == 2 && !m_out); i++) tick(1'b0, '0);
        n_checks++; if (!(m_q.size() == 2 && !m_out)) $display("FAIL ra_setup timeout size=%0d", m_q.size()); else n_pass++;
        n_checks++; if (fq_valid !== 1'b1 || imem_req_valid !== 1'b1)
            $display("FAIL ra_pre fq_valid=%b req_valid=%b exp 1/1", fq_valid, imem_req_valid);
        else n_pass++;
        pop_pct = 100;
        tick(1'b1, 32'h0000_0C00);
        n_checks++; if (!ev_accept) $display("FAIL ra_same_accept got=0 exp=1"); else n_pass++;
        n_checks++; if (fq_valid !== 1'b0 || imem_req_valid !== 1'b0 || program_counter !== 32'hC00)
            $display("FAIL ra_after fq_valid=%b req_valid=%b pc=%h exp 0/0/c00", fq_valid, imem_req_valid, program_counter);
        else n_pass++;
        tick(1'b0, '0);
        n_checks++; if (fq_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC00)
            $display("FAIL ra_drain fq_valid=%b req_valid=%b addr=%h exp 0/1/c00", fq_valid, imem_req_valid, imem_req_addr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        ready_pct = 0; pop_pct = 100; mem_lat = 1;
        tick(1'b1, 32'hFFFF_FFFC);
        ready_pct = 100;
        tick(1'b0, '0);
        n_checks++; if (!ev_accept || ev_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req accept=%b addr=%h exp=fffffffc", ev_accept, ev_addr); else n_pass++;
        n_checks++; if (program_counter !== 32'h0) $display("FAIL wrap_pc got=%h exp=0", program_counter); else n_pass++;
        tick(1'b0, '0);
        tick(1'b0, '0);
        n_checks++; if (!ev_accept || ev_addr !== 32'h0) $display("FAIL wrap_next_req accept=%b addr=%h exp=0", ev_accept, ev_addr); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        bit          redir;
        int          errs;
        errs = 0;
        pred_rand = 1'b1; spurious = 1'b1; ready_pct = 70; pop_pct = 50;
        for (int i = 0; i < 2000; i++) begin
            mem_lat = $urandom_range(4, 1);
            redir = ($urandom_range(15) == 0);
            rpc = $urandom;
            rpc[1:0] = 2'b00;
            if ($urandom_range(7) == 0) rpc = 32'hFFFF_FFFC;
            tick(redir, rpc);
            if (ev_accept) begin
                n_checks++; if (ev_addr !== ev_exp) begin
                    if (errs++ < 10) $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", i, ev_addr, ev_exp);
                end else n_pass++;
            end
            n_checks++; if (program_counter !== m_pc) begin
                if (errs++ < 10) $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, program_counter, m_pc);
            end else n_pass++;
            n_checks++; if (imem_req_valid !== (!m_out && m_q.size() < DEPTH)) begin
                if (errs++ < 10) $display("FAIL rnd_req_valid cyc=%0d got=%b exp=%b", i, imem_req_valid, !m_out && m_q.size() < DEPTH);
            end else n_pass++;
            n_checks++; if (fq_valid !== (m_q.size() != 0)) begin
                if (errs++ < 10) $display("FAIL rnd_fq_valid cyc=%0d got=%b exp=%b", i, fq_valid, m_q.size() != 0);
            end else n_pass++;
            if (m_q.size() != 0) begin
                n_checks++;
                if (fq_instr !== m_q[0].instr || fq_pc !== m_q[0].pc ||
                    fq_pred_taken !== m_q[0].taken || fq_pred_target !== m_q[0].target) begin
                    if (errs++ < 10) $display("FAIL rnd_head cyc=%0d got=%h/%h/%b/%h exp=%h/%h/%b/%h", i,
                        fq_instr, fq_pc, fq_pred_taken, fq_pred_target,
                        m_q[0].instr, m_q[0].pc, m_q[0].taken, m_q[0].target);
                end else n_pass++;
            end
        end
        pred_rand = 1'b0; spurious = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_predict();
        test_full();
        test_redirect_wait();
        test_redirect_accept();
        test_wrap();
        test_random();
        test_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
